decoder_arbiter: RTL and testbench
==================================

DECODER_ARBITER -- requirements
Module: decoder_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 8, meaning number of requesters (fixed at 8; 3-bit index).
REQ-002 The block SHALL have parameter HOLD_MAX, default 16, meaning maximum grant tenure in cycles (used only with ARB_TIMEOUT_EN).
REQ-003 The block SHALL have port clk  input  1  rising-edge system clock.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req  input  8  per-requester request, held high for the whole tenure.
REQ-006 The block SHALL have port gnt  output  8  one-hot grant, all zero when no grant.
REQ-007 The block SHALL have port gnt_idx  output  3  binary index of current or last grantee.
REQ-008 The block SHALL have port gnt_valid  output  1  high while any grant is active.
REQ-009 The block SHALL have port timeout  output  1  one-cycle pulse on forced revocation.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-011 gnt SHALL be the 3-to-8 one-hot decode of gnt_idx, enabled only in GRANT; gnt SHALL be 8'h00 in IDLE.
REQ-012 gnt_valid SHALL equal (state == GRANT); gnt, gnt_valid and gnt_idx SHALL be driven from registers only (no combinational path from req).
REQ-013 A 3-bit round-robin pointer ptr SHALL hold the highest-priority index; priority order is ptr, ptr+1, ..., ptr+7, mod 8.
REQ-014 In IDLE with req != 0 at a clock edge, the block SHALL enter GRANT and load gnt_idx with the first asserted requester in priority order; latency from req rise to gnt is 1 cycle.
REQ-015 In IDLE with req == 0, state, gnt_idx and ptr SHALL hold.
REQ-016 In GRANT, the grant SHALL persist while req[gnt_idx] is high; changes on other req bits SHALL be ignored.
REQ-017 In GRANT, when req[gnt_idx] is sampled low, the block SHALL return to IDLE next cycle and set ptr = gnt_idx + 1 (3-bit wrap, 7 -> 0).
REQ-018 At least one IDLE cycle SHALL separate consecutive grants (no grant-to-grant handover in one cycle).
REQ-019 A requester that re-asserts immediately after release SHALL lose to any other pending requester, and SHALL win if it is the only one pending.
REQ-020 gnt_idx SHALL retain the last grantee value in IDLE.
REQ-021 The timeout output SHALL be 0 at all times when ARB_TIMEOUT_EN is undefined.

Reset
REQ-022 On rst low, asynchronously: state = IDLE, gnt = 8'h00, gnt_idx = 0, gnt_valid = 0, timeout = 0, ptr = 0, hold counter = 0.
REQ-023 Reset asserted mid-GRANT SHALL drop gnt within the same cycle without a timeout pulse; the first grant after reset release SHALL use ptr = 0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN SHALL compile in tenure limiting; without it, no hold counter exists and grants last until release.
REQ-025 With ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to GRANT and increment each GRANT cycle; when the grant has lasted HOLD_MAX cycles with req[gnt_idx] still high, the block SHALL go to IDLE, pulse timeout for 1 cycle, and set ptr = gnt_idx + 1.
REQ-026 With ARB_TIMEOUT_EN defined, a release on the same cycle the limit is reached SHALL be treated as a normal release (no timeout pulse).

Verification
REQ-027 After reset, req = 8'b0000_0100 -> next cycle gnt = 8'h04, gnt_idx = 2, gnt_valid = 1; drop req -> next cycle gnt = 8'h00.
REQ-028 req = 8'hFF held, each grantee drops after 3 cycles then re-raises -> grant order 0,1,2,...,7,0 with one IDLE cycle between grants.
REQ-029 Grant to 7, release, req = 8'h81 -> next grant index 0 (wrap), then 7.
REQ-030 Grant to 3, rst pulsed low mid-tenure -> gnt = 8'h00 immediately, timeout = 0; after release, req = 8'h88 -> grant index 3.
REQ-031 With ARB_TIMEOUT_EN defined and HOLD_MAX = 4: req = 8'h03 held -> gnt = 8'h01 for 4 cycles, timeout pulse, IDLE cycle, then gnt = 8'h02.
REQ-032 Without ARB_TIMEOUT_EN: req = 8'h01 held 100 cycles -> gnt = 8'h01 throughout, timeout never asserted.

Source files
------------

// File: rtl/decoder_arbiter.sv
// Round-robin 8-way arbiter: two-state FSM, registered one-hot grant held until release.
// Define ARB_TIMEOUT_EN to cap each tenure at HOLD_MAX cycles with a timeout pulse.
module decoder_arbiter #(
  parameter int N_REQ    = 8,
  parameter int HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int IW = 3;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] ptr, ptr_nx, idx_nx, pick, cand;
  logic          any_req, own_req, hit_limit, found;

  generate
    if (N_REQ != 8 || HOLD_MAX < 1) begin : g_bad_param
      $error("decoder_arbiter: N_REQ must be 8 and HOLD_MAX >= 1");
    end
  endgenerate

  assign any_req = |req;
  assign own_req = req[gnt_idx];

  // First asserted requester scanning ptr, ptr+1, ... with natural 3-bit wrap.
  always_comb begin
    pick  = ptr;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + IW'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);

  logic [CW-1:0] hold_cnt;
  logic          tmo_q;

  // hold_cnt counts completed GRANT cycles minus one; IDLE keeps it cleared for the next entry.
  assign hit_limit = (hold_cnt == CW'(HOLD_MAX - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      tmo_q <= (state == GRANT) && own_req && hit_limit;
      if (state == GRANT && state_nx == GRANT) hold_cnt <= hold_cnt + 1'b1;
      else                                     hold_cnt <= '0;
    end
  end

  assign timeout = tmo_q;
`else
  assign hit_limit = 1'b0;
  assign timeout   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_nx;
      gnt_idx <= idx_nx;
      ptr     <= ptr_nx;
    end
  end

  // Next-state logic; release takes priority over the tenure limit.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = GRANT;
      GRANT:   if (!own_req || hit_limit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath updates: load index on entry, advance pointer past the grantee on exit.
  always_comb begin
    idx_nx = gnt_idx;
    ptr_nx = ptr;
    if (state == IDLE && any_req) idx_nx = pick;
    if (state == GRANT && state_nx == IDLE) ptr_nx = gnt_idx + 1'b1;
  end

  assign gnt_valid = (state == GRANT);

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_dec
      assign gnt[i] = gnt_valid && (gnt_idx == IW'(i));
    end
  endgenerate

endmodule

// File: tb/tb_decoder_arbiter.sv
// Randomized + directed bench for decoder_arbiter against a tenure-based reference model.
module tb_decoder_arbiter;
`ifdef ARB_TIMEOUT_EN
  localparam int HM = 4;
  localparam bit TO = 1'b1;
`else
  localparam int HM = 16;
  localparam bit TO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid, timeout;

  int vecs = 0, errs = 0;

  // Reference model: owner of the current tenure, how long it has lasted, rotation start.
  bit m_busy = 0, m_tmo = 0;
  int m_owner = 0, m_ptr = 0, m_ten = 0;

  decoder_arbiter #(.N_REQ(8), .HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_tmo = 0; m_owner = 0; m_ptr = 0; m_ten = 0;
  endtask

  task automatic model_edge(input logic [7:0] r);
    m_tmo = 0;
    if (!m_busy) begin
      if (r != 0) begin
        for (int k = 0; k < 8; k++)
          if (r[(m_ptr + k) % 8]) begin m_owner = (m_ptr + k) % 8; break; end
        m_busy = 1; m_ten = 1;
      end
    end else if (!r[m_owner]) begin
      m_busy = 0; m_ptr = (m_owner + 1) % 8;
    end else if (TO && m_ten >= HM) begin
      m_busy = 0; m_tmo = 1; m_ptr = (m_owner + 1) % 8;
    end else m_ten++;
  endtask

  task automatic check_model();
    logic [7:0] eg;
    eg = m_busy ? (8'h01 << m_owner) : 8'h00;
    chk("gnt", gnt, eg);
    chk("gnt_idx", {5'd0, gnt_idx}, 8'(m_owner));
    chk("gnt_valid", {7'd0, gnt_valid}, {7'd0, m_busy});
    chk("timeout", {7'd0, timeout}, {7'd0, m_tmo});
  endtask

  task automatic step(input logic [7:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    check_model();
  endtask

  // Async reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_gnt", gnt, 8'h00);
    chk("rst_tmo", {7'd0, timeout}, 8'h00);
    check_model();
    @(posedge clk);
    #1;
    check_model();
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    int exp_order [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

    #2;
    chk("reset_gnt", gnt, 8'h00);
    chk("reset_idx", {5'd0, gnt_idx}, 8'h00);
    chk("reset_valid", {7'd0, gnt_valid}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single requester, one-cycle latency, release.
    step(8'h04);
    chk("d1_gnt", gnt, 8'h04);
    chk("d1_idx", {5'd0, gnt_idx}, 8'd2);
    chk("d1_valid", {7'd0, gnt_valid}, 8'h01);
    step(8'h00);
    chk("d1_rel", gnt, 8'h00);
    chk("d1_idx_hold", {5'd0, gnt_idx}, 8'd2);

    // All request; each tenure 3 cycles, one IDLE gap, re-raiser loses.
    do_reset();
    step(8'hFF);
    for (int g = 0; g < 9; g++) begin
      chk("rr_valid", {7'd0, gnt_valid}, 8'h01);
      chk("rr_idx", {5'd0, gnt_idx}, 8'(exp_order[g]));
      step(8'hFF);
      step(8'hFF);
      r = 8'hFF & ~(8'h01 << gnt_idx);
      step(r);
      chk("rr_gap", {7'd0, gnt_valid}, 8'h00);
      step(8'hFF);
    end

    // Wrap: grant 7, release, then 0 and 7 together.
    do_reset();
    step(8'h80);
    chk("w_7", gnt, 8'h80);
    step(8'h00);
    step(8'h81);
    chk("w_0", {5'd0, gnt_idx}, 8'd0);
    step(8'h81);
    step(8'h80);
    chk("w_gap", gnt, 8'h00);
    step(8'h80);
    chk("w_7b", {5'd0, gnt_idx}, 8'd7);
    step(8'h00);

    // Reset mid-tenure restores ptr = 0.
    step(8'h08);
    chk("r_3", gnt, 8'h08);
    step(8'h08);
    do_reset();
    step(8'h00);
    step(8'h88);
    chk("r_after", {5'd0, gnt_idx}, 8'd3);
    step(8'h00);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    for (int c = 0; c < 4; c++) begin
      step(8'h03);
      chk("to_hold", gnt, 8'h01);
      chk("to_notmo", {7'd0, timeout}, 8'h00);
    end
    step(8'h03);
    chk("to_pulse", {7'd0, timeout}, 8'h01);
    chk("to_idle", gnt, 8'h00);
    step(8'h03);
    chk("to_next", gnt, 8'h02);
    chk("to_clr", {7'd0, timeout}, 8'h00);
    step(8'h00);
`else
    do_reset();
    for (int c = 0; c < 100; c++) begin
      step(8'h01);
      chk("hold_gnt", gnt, 8'h01);
      chk("hold_tmo", {7'd0, timeout}, 8'h00);
    end
    step(8'h00);
`endif

    // Random traffic with occasional resets.
    r = 8'h00;
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 199) == 0) do_reset();
      else step(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
